fifo_read_packer: RTL

- Read-side consumer placed directly downstream of the team's synchronous FIFO.
- Drains FIFO_WIDTH-bit entries through the FIFO's rd_en/data_out/empty interface and packs PACK_RATIO consecutive entries into one wide output word.
- Presents packed words on a valid/ready stream with a lane count, so downstream logic can consume wide words.
- A flush request emits a partially filled word.

---
 rtl/fifo_read_packer_if.sv | 28 ++
 rtl/fifo_read_packer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fifo_read_packer_if.sv
// Bundle of the FIFO read side, flush request and packed output stream for fifo_read_packer.
// The master modport is the packer's view; slave is the view of the FIFO/downstream environment.
interface fifo_read_packer_if #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned PACK_RATIO = 4,
    parameter int unsigned CNT_W      = $clog2(PACK_RATIO + 1)
);
    logic                             fifo_empty;
    logic                             fifo_underflow;
    logic [FIFO_WIDTH-1:0]            fifo_data_out;
    logic                             fifo_rd_en;
    logic                             flush;
    logic [FIFO_WIDTH*PACK_RATIO-1:0] out_data;
    logic [CNT_W-1:0]                 out_count;
    logic                             out_valid;
    logic                             out_ready;
    logic                             err;

    modport master (
        input  fifo_empty, fifo_underflow, fifo_data_out, flush, out_ready,
        output fifo_rd_en, out_data, out_count, out_valid, err
    );

    modport slave (
        output fifo_empty, fifo_underflow, fifo_data_out, flush, out_ready,
        input  fifo_rd_en, out_data, out_count, out_valid, err
    );
endinterface

// File: rtl/fifo_read_packer.sv
// Drains a synchronous FIFO and packs PACK_RATIO entries per output word, with partial-word flush.
// Define FIFO_READ_PACKER_ERR_EN to build the sticky underflow/protocol error flag on err.
module fifo_read_packer #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned PACK_RATIO = 4
) (
    input logic                clk,
    input logic                rst,
    fifo_read_packer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(PACK_RATIO + 1);

    localparam logic [CNT_W-1:0] RATIO_CNT = CNT_W'(PACK_RATIO);
    localparam logic [CNT_W:0]   RATIO_EXT = (CNT_W + 1)'(PACK_RATIO);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    typedef logic [PACK_RATIO-1:0][FIFO_WIDTH-1:0] lanes_t;

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 word_cnt_q, word_cnt_d;
    logic                             rd_pend_q;
    logic                             flush_req_q, flush_req_d;
    lanes_t                           lanes_q, lanes_d;
    logic                             out_valid_q, out_valid_d;
    logic [FIFO_WIDTH*PACK_RATIO-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]                 out_count_q, out_count_d;

    logic             rd_en;
    logic             out_free;
    lanes_t           lanes_merged;
    logic [CNT_W-1:0] cnt_new;

    // In-flight reads count against the word so no entry arrives without a free lane.
    assign rd_en = !bus.fifo_empty && (state_q == StFill) && !flush_req_q &&
                   (({1'b0, word_cnt_q} + (CNT_W + 1)'(rd_pend_q)) < RATIO_EXT);

    assign out_free = !out_valid_q || bus.out_ready;

    always_comb begin
        lanes_merged = lanes_q;
        cnt_new      = word_cnt_q;
        if (rd_pend_q) begin
            for (int i = 0; i < int'(PACK_RATIO); i++) begin
                if (CNT_W'(i) == word_cnt_q) begin
                    lanes_merged[i] = bus.fifo_data_out;
                end
            end
            cnt_new = word_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        lanes_d     = lanes_q;
        flush_req_d = flush_req_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (bus.flush && !flush_req_q) begin
            flush_req_d = 1'b1;
        end

        unique case (state_q)
            StFill: begin
                if (rd_pend_q) begin
                    if (cnt_new == RATIO_CNT && out_free) begin
                        out_data_d  = lanes_merged;
                        out_count_d = RATIO_CNT;
                        out_valid_d = 1'b1;
                        word_cnt_d  = '0;
                        lanes_d     = '0;
                    end else begin
                        lanes_d    = lanes_merged;
                        word_cnt_d = cnt_new;
                        if (cnt_new == RATIO_CNT) begin
                            state_d = StHold;
                        end
                    end
                end else if (flush_req_q) begin
                    if (word_cnt_q == '0) begin
                        flush_req_d = 1'b0;
                    end else if (out_free) begin
                        // Lanes above word_cnt are already zero since every emit clears them.
                        out_data_d  = lanes_q;
                        out_count_d = word_cnt_q;
                        out_valid_d = 1'b1;
                        word_cnt_d  = '0;
                        lanes_d     = '0;
                        flush_req_d = 1'b0;
                    end
                end
            end
            StHold: begin
                if (out_free) begin
                    out_data_d  = lanes_q;
                    out_count_d = RATIO_CNT;
                    out_valid_d = 1'b1;
                    word_cnt_d  = '0;
                    lanes_d     = '0;
                    state_d     = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFill;
            word_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            flush_req_q <= 1'b0;
            lanes_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            rd_pend_q   <= rd_en;
            flush_req_q <= flush_req_d;
            lanes_q     <= lanes_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_count  = out_count_q;

`ifdef FIFO_READ_PACKER_ERR_EN
    logic empty_q;
    logic err_q;

    // empty_q is the empty flag of the cycle that issued the read now pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            empty_q <= bus.fifo_empty;
            if (bus.fifo_underflow || (rd_pend_q && empty_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule
